// File: rtl/rop3_blit_ctrl.sv
// Blit controller: streams P/S/D pixels from memory through an external
// ROP3 core and writes each result back to D, in address order.
module rop3_blit_ctrl #(
    parameter int N   = 5,
    parameter int AW  = 8,
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [7:0]    mode_in,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [N-1:0]  mem_p,
    input  logic [N-1:0]  mem_s,
    input  logic [N-1:0]  mem_d,
    output logic [N-1:0]  rop_p,
    output logic [N-1:0]  rop_s,
    output logic [N-1:0]  rop_d,
    output logic [7:0]    rop_mode,
    input  logic [N-1:0]  rop_result,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [N-1:0]  wr_data
);

    // Read at cycle t is written back at cycle t+2+LAT: one memory cycle,
    // one operand register, then LAT core stages.
    localparam int PD = LAT + 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   i_q, i_d;
    logic [AW-1:0] base_q, base_d;
    logic [7:0]    rop_mode_q, rop_mode_d;
    logic [N-1:0]  rop_p_q, rop_p_d;
    logic [N-1:0]  rop_s_q, rop_s_d;
    logic [N-1:0]  rop_d_q, rop_d_d;
    logic [PD-1:0] vld_q, vld_d;
    logic [AW-1:0] addr_q [PD];
    logic [AW-1:0] addr_d [PD];

    logic          rd_en_w;
    logic [AW-1:0] rd_addr_w;
    logic          pending;
    logic          kill;

    assign rd_addr_w = base_q + i_q[AW-1:0];
    assign pending   = |vld_q[PD-2:0];

    // NOTE: every signal written below gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        i_d        = i_q;
        base_d     = base_q;
        rop_mode_d = rop_mode_q;
        rd_en_w    = 1'b0;
        kill       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    rop_mode_d = mode_in;
                    base_d     = base_addr;
                    len_d      = len;
                    i_d        = '0;
                    state_d    = (len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                rd_en_w = 1'b1;
                i_d     = i_q + (AW+1)'(1);
                if (abort) begin
                    kill    = 1'b1;
                    state_d = ST_IDLE;
                end else if (i_q == len_q - (AW+1)'(1)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    kill    = 1'b1;
                    state_d = ST_IDLE;
                end else if (vld_q[PD-1] && !pending) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Valid/address alignment pipe and operand capture.
    always_comb begin
        vld_d     = {vld_q[PD-2:0], rd_en_w};
        addr_d[0] = rd_addr_w;
        for (int k = 1; k < PD; k++) begin
            addr_d[k] = addr_q[k-1];
        end
        if (kill) begin
            vld_d = '0;
        end

        rop_p_d = rop_p_q;
        rop_s_d = rop_s_q;
        rop_d_d = rop_d_q;
        if (vld_q[0]) begin
            rop_p_d = mem_p;
            rop_s_d = mem_s;
            rop_d_d = mem_d;
        end
    end

    // NOTE: the address pipe is reset along with everything else because
    // its last stage drives wr_addr, which must read zero out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            i_q        <= '0;
            base_q     <= '0;
            rop_mode_q <= '0;
            rop_p_q    <= '0;
            rop_s_q    <= '0;
            rop_d_q    <= '0;
            vld_q      <= '0;
            for (int k = 0; k < PD; k++) begin
                addr_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            i_q        <= i_d;
            base_q     <= base_d;
            rop_mode_q <= rop_mode_d;
            rop_p_q    <= rop_p_d;
            rop_s_q    <= rop_s_d;
            rop_d_q    <= rop_d_d;
            vld_q      <= vld_d;
            for (int k = 0; k < PD; k++) begin
                addr_q[k] <= addr_d[k];
            end
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign rd_en    = rd_en_w;
    assign rd_addr  = rd_addr_w;
    assign rop_p    = rop_p_q;
    assign rop_s    = rop_s_q;
    assign rop_d    = rop_d_q;
    assign rop_mode = rop_mode_q;
    assign wr_en    = vld_q[PD-1];
    assign wr_addr  = addr_q[PD-1];
    assign wr_data  = rop_result;

endmodule

// File: tb/tb_rop3_blit_ctrl.sv
// Randomized bench for rop3_blit_ctrl: bench-side memories and ROP3 core,
// per-cycle expectations derived from the blit timing rules.
module tb_rop3_blit_ctrl;

    localparam int N     = 5;
    localparam int AW    = 8;
    localparam int LAT   = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [7:0]    mode_in = '0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   len = '0;
    logic          busy, done, rd_en, wr_en;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [N-1:0]  mem_p = '0, mem_s = '0, mem_d = '0;
    logic [N-1:0]  rop_p, rop_s, rop_d, rop_result, wr_data;
    logic [7:0]    rop_mode;

    int errors = 0;
    int checks = 0;

    rop3_blit_ctrl #(.N(N), .AW(AW), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .mode_in(mode_in), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
        .mem_p(mem_p), .mem_s(mem_s), .mem_d(mem_d),
        .rop_p(rop_p), .rop_s(rop_s), .rop_d(rop_d), .rop_mode(rop_mode),
        .rop_result(rop_result), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    // Bitwise ROP3: each result bit selects mode bit {P,S,D}.
    function automatic logic [N-1:0] rop3(input logic [7:0] m, input logic [N-1:0] p,
                                          input logic [N-1:0] s, input logic [N-1:0] d);
        logic [N-1:0] r;
        for (int b = 0; b < N; b++) begin
            r[b] = m[{p[b], s[b], d[b]}];
        end
        return r;
    endfunction

    logic [N-1:0] mem_pa [DEPTH];
    logic [N-1:0] mem_sa [DEPTH];
    logic [N-1:0] mem_da [DEPTH];

    always @(posedge clk) begin
        if (rd_en) begin
            mem_p <= mem_pa[rd_addr];
            mem_s <= mem_sa[rd_addr];
            mem_d <= mem_da[rd_addr];
        end
        if (wr_en) begin
            mem_da[wr_addr] <= wr_data;
        end
    end

    logic [N-1:0] core_q [LAT];
    always @(posedge clk) begin
        core_q[0] <= rop3(rop_mode, rop_p, rop_s, rop_d);
        for (int k = 1; k < LAT; k++) begin
            core_q[k] <= core_q[k-1];
        end
    end
    assign rop_result = core_q[LAT-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One blit issued from IDLE. abort_at / xstart_at / rst_at are cycle
    // numbers relative to the start edge (0 = not used).
    task automatic run_blit(input int base, input int ln, input int mode,
                            input int abort_at, input int xstart_at, input int rst_at);
        logic [N-1:0] exp_data [$];
        logic [N-1:0] exp_s [$];
        int  a, wi;
        bit  killed, was_rst, e_rd, e_wr, e_done, e_busy;
        for (int k = 0; k < ln; k++) begin
            a = (base + k) % DEPTH;
            exp_data.push_back(rop3(mode[7:0], mem_pa[a], mem_sa[a], mem_da[a]));
            exp_s.push_back(mem_sa[a]);
        end
        @(negedge clk);
        start     = 1'b1;
        mode_in   = mode[7:0];
        base_addr = base[AW-1:0];
        len       = ln[AW:0];
        for (int c = 1; c <= ln + LAT + 6; c++) begin
            @(negedge clk);
            was_rst = (rst_at > 0 && c > rst_at);
            killed  = was_rst || (abort_at > 0 && c > abort_at);
            if (ln == 0) begin
                e_rd = 0; e_wr = 0; e_done = (c == 1); e_busy = (c == 1);
            end else begin
                e_rd   = (c <= ln);
                e_wr   = (c >= LAT + 3) && (c <= ln + LAT + 2);
                e_done = (c == ln + LAT + 3);
                e_busy = (c <= ln + LAT + 3);
            end
            if (killed) begin
                e_rd = 0; e_wr = 0; e_done = 0; e_busy = 0;
            end
            check("busy", busy, e_busy);
            check("done", done, e_done);
            check("rd_en", rd_en, e_rd);
            check("wr_en", wr_en, e_wr);
            if (e_rd) check("rd_addr", rd_addr, (base + c - 1) % DEPTH);
            if (e_wr) begin
                wi = c - LAT - 3;
                check("wr_addr", wr_addr, (base + wi) % DEPTH);
                check("wr_data", wr_data, exp_data[wi]);
            end
            if (!killed && c >= 3 && c <= ln + 2) check("rop_s", rop_s, exp_s[c-3]);
            if (!killed && ln > 0 && c <= ln + LAT + 3) check("rop_mode", rop_mode, mode[7:0]);
            if (was_rst) begin
                check("rst_rd_addr", rd_addr, 0);
                check("rst_wr_addr", wr_addr, 0);
                check("rst_rop_p", rop_p, 0);
                check("rst_rop_s", rop_s, 0);
                check("rst_rop_d", rop_d, 0);
                check("rst_rop_mode", rop_mode, 0);
            end
            start = (c == xstart_at);
            if (c == xstart_at) begin
                mode_in   = 8'h00;
                base_addr = AW'($urandom);
                len       = (AW+1)'($urandom_range(1, 20));
            end
            abort = (c == abort_at);
            rst   = (c == rst_at);
        end
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
    endtask

    initial begin
        int ln, ab;
        for (int i = 0; i < DEPTH; i++) begin
            mem_pa[i] = N'($urandom);
            mem_sa[i] = N'($urandom);
            mem_da[i] = N'($urandom);
        end
        for (int k = 0; k < LAT; k++) core_q[k] = '0;

        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_rd_en", rd_en, 0);
        check("reset_wr_en", wr_en, 0);
        check("reset_rd_addr", rd_addr, 0);
        check("reset_wr_addr", wr_addr, 0);
        check("reset_rop_mode", rop_mode, 0);
        check("reset_rop_p", rop_p, 0);
        rst = 1'b0;

        run_blit(8'h10, 4, 8'hCC, 0, 0, 0);
        run_blit(8'hFE, 4, $urandom_range(0, 255), 0, 0, 0);
        run_blit($urandom_range(0, 255), 0, 8'h5A, 0, 0, 0);
        run_blit($urandom_range(0, 255), 8, $urandom_range(0, 255), 2, 0, 0);
        run_blit($urandom_range(0, 255), 5, $urandom_range(0, 255), 0, 0, 0);
        run_blit($urandom_range(0, 255), 6, 8'hA5, 0, 3, 0);
        run_blit($urandom_range(0, 255), 3, 8'h96, 0, 3 + LAT + 3, 0);
        run_blit($urandom_range(0, 255), 6, $urandom_range(0, 255), 0, 0, 8);
        run_blit($urandom_range(0, 255), 5, $urandom_range(0, 255), 7, 0, 0);
        run_blit($urandom_range(0, 255), 1, $urandom_range(0, 255), 0, 0, 0);
        run_blit($urandom_range(0, 255), DEPTH, $urandom_range(0, 255), 0, 0, 0);

        // abort together with start in IDLE: start must not be taken
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        len   = 9'd4;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("abort_start_busy", busy, 0);
        check("abort_start_rd_en", rd_en, 0);
        @(negedge clk);
        check("abort_start_busy2", busy, 0);

        for (int r = 0; r < 12; r++) begin
            ln = $urandom_range(0, 40);
            ab = 0;
            if (ln > 0 && $urandom_range(0, 3) == 0) ab = $urandom_range(1, ln + LAT + 2);
            run_blit($urandom_range(0, 255), ln, $urandom_range(0, 255), ab, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rop3_blit_ctrl.md
ROP3_BLIT_CTRL -- requirements
Module: rop3_blit_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  N    5  pixel width, bits
  AW   8  memory address width
  LAT  2  ROP3 core latency, rising edges from inputs sampled to Result valid
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk         in   1     single clock, rising edge
  rst         in   1     synchronous, active-high reset
  start       in   1     begin blit; sampled only in IDLE
  abort       in   1     cancel current blit
  mode_in     in   8     ROP3 mode; captured at accepted start
  base_addr   in   AW    first pixel address; captured at accepted start
  len         in   AW+1  pixel count, 0..2^AW; captured at accepted start
  busy        out  1     high in RUN/DRAIN/DONE
  done        out  1     one-cycle completion pulse
  rd_en       out  1     read strobe to P/S/D memories
  rd_addr     out  AW    read address, shared by all three memories
  mem_p       in   N     P read data, valid 1 cycle after rd_en
  mem_s       in   N     S read data, valid 1 cycle after rd_en
  mem_d       in   N     D read data, valid 1 cycle after rd_en
  rop_p       out  N     registered P operand to ROP3 core
  rop_s       out  N     registered S operand to ROP3 core
  rop_d       out  N     registered D operand to ROP3 core
  rop_mode    out  8     registered mode to ROP3 core
  rop_result  in   N     ROP3 core Result
  wr_en       out  1     D-memory write strobe
  wr_addr     out  AW    write address
  wr_data     out  N     write data (= rop_result)

Function
REQ-003 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-004 IDLE & start=1 & len>0 -> RUN; capture mode_in, base_addr, len; issue counter i=0.
REQ-005 IDLE & start=1 & len=0 -> DONE; no reads, no writes.
REQ-006 RUN: rd_en=1 every cycle; rd_addr = base_addr+i mod 2^AW (wraps 2^AW-1 -> 0); i increments each cycle.
REQ-007 RUN -> DRAIN in the cycle after the read with i=len-1; reads are back-to-back, no gaps.
REQ-008 Cycle t+1 after a read at cycle t: mem_* registered into rop_p/s/d at the t+1 edge; operands visible from cycle t+2.
REQ-009 The write for a read at cycle t asserts wr_en at cycle t+2+LAT, with wr_addr = that read address and wr_data = rop_result combinationally.
REQ-010 Alignment via valid/address shift register, depth 2+LAT; exactly len writes per blit, in address order.
REQ-011 DRAIN -> DONE in the cycle after the last write; DONE lasts one cycle with done=1, then -> IDLE.
REQ-012 rop_mode holds the captured mode for the entire blit, including DRAIN; it updates only at an accepted start.
REQ-013 start while busy=1 is ignored; start arriving in the DONE cycle is also ignored.
REQ-014 abort=1 in RUN/DRAIN -> IDLE next edge; valid pipeline cleared; no further wr_en; no done pulse.
REQ-015 abort in IDLE or DONE has no effect; abort and start together in IDLE: abort wins, no start accepted.
REQ-016 len=2^AW: every address visited exactly once, wrapping from base_addr.
REQ-017 Overlapping read/write of the same address is the memory's responsibility; the controller does not stall.

Reset
REQ-018 rst=1 at a rising edge: state IDLE; i=0; pipeline valids 0.
REQ-019 Output reset values: busy, done, rd_en, wr_en = 0; rd_addr, wr_addr, rop_p, rop_s, rop_d, rop_mode = 0.
REQ-020 rst takes priority over start and abort, and aborts any blit mid-operation without a done pulse.

Verification
REQ-021 Blit: start, base=0x10, len=4, mode=0xCC -> rd_addr 0x10..0x13 on cycles 1-4; wr_en on cycles 5-8 (LAT=2) with wr_data=S; single done in cycle 9.
REQ-022 Wrap: base=0xFE, len=4 -> rd_addr FE, FF, 00, 01; writes to the same addresses in the same order.
REQ-023 len=0 -> done one cycle after start; rd_en and wr_en never asserted.
REQ-024 abort in the 2nd RUN cycle of len=8 -> IDLE next cycle; no further wr_en; done stays 0; a fresh start is accepted after.
REQ-025 start pulsed during busy with mode=0x00 -> ignored; rop_mode unchanged; write count equals the original len.
REQ-026 rst asserted in DRAIN -> all outputs at reset values next cycle; no done pulse.
